// File: rtl/sub_bytes_multicycle.sv
// Multicycle SubBytes / InvSubBytes engine: one 128-bit state per transaction,
// LANES bytes substituted per clock, result held until the downstream stage takes it.
module sub_bytes_multicycle #(
  parameter int LANES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_inverse,
  output logic [1:0]   dbg_state
);

  localparam int PASSES = 16 / LANES;
  localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_multicycle: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    work_q;
  logic [127:0]    work_d;
  logic            mode_q;
  logic            out_valid_q;
  logic            accept;
  logic            last_pass;
  int              lane_idx;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = prod x^(2^k), k = 1..7; maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward: affine(inv(b)); inverse: inv(inverse_affine(b)).
  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    logic [7:0] t;
    if (inv) begin
      t = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
      return ginv(t);
    end else begin
      t = ginv(b);
      return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    end
  endfunction

  always_comb begin
    work_d   = work_q;
    lane_idx = 0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx = int'(cnt_q) * LANES + l;
      work_d[127 - 8*lane_idx -: 8] = sbox(work_q[127 - 8*lane_idx -: 8], mode_q);
    end
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds valid and payload stable until then, and ready never waits on valid.
  assign in_ready  = !reset && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign last_pass = (cnt_q == CW'(PASSES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            work_q  <= in_data;
            mode_q  <= in_inverse;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (last_pass) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              work_q  <= in_data;
              mode_q  <= in_inverse;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = work_q;
  assign out_inverse = mode_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sub_bytes_multicycle.sv
// Directed bench for sub_bytes_multicycle: FIPS-197 vectors, back-pressure,
// back-to-back accept, reset abort, mode isolation and a LANES sweep (1, 2, 8, 16).
module tb_sub_bytes_multicycle;

  localparam logic [127:0] V_PT   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V_SB   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ZERO   = 128'h0;
  localparam logic [127:0] ALL63  = {16{8'h63}};
  localparam logic [127:0] ALL52  = {16{8'h52}};
  localparam logic [1:0]   ST_IDLE = 2'd0;
  localparam logic [1:0]   ST_BUSY = 2'd1;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         d_in_valid, d_in_ready, d_in_inverse, d_out_valid, d_out_ready, d_out_inverse;
  logic [127:0] d_in_data, d_out_data;
  logic [1:0]   d_dbg;

  logic         s_in_valid, s_in_inverse, s_out_ready;
  logic [127:0] s_in_data;
  logic [3:0]   s_in_ready, s_out_valid, s_out_inverse;
  logic [127:0] s_out_data [4];
  logic [1:0]   s_dbg [4];

  int total = 0;
  int bad   = 0;
  int exp_lat [4] = '{16, 8, 2, 1};

  sub_bytes_multicycle #(.LANES(4)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_inverse(d_in_inverse),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_inverse(d_out_inverse), .dbg_state(d_dbg)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int LV = (g < 2) ? (1 << g) : (1 << (g + 1));
    sub_bytes_multicycle #(.LANES(LV)) u_sw (
      .clock(clock), .reset(reset),
      .in_valid(s_in_valid), .in_ready(s_in_ready[g]), .in_data(s_in_data), .in_inverse(s_in_inverse),
      .out_valid(s_out_valid[g]), .out_ready(s_out_ready), .out_data(s_out_data[g]),
      .out_inverse(s_out_inverse[g]), .dbg_state(s_dbg[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge just after the accepting edge.
  task automatic wait_main(output int lat, output logic busy_rdy);
    lat = 0;
    busy_rdy = 1'b0;
    while (!d_out_valid && lat < 40) begin
      busy_rdy = busy_rdy | d_in_ready;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_main(input logic [127:0] data, input logic inv, output int lat, output logic busy_rdy);
    @(negedge clock);
    chk("accept_in_ready", d_in_ready, 1'b1);
    d_in_valid = 1'b1; d_in_data = data; d_in_inverse = inv;
    @(negedge clock);
    d_in_valid = 1'b0;
    wait_main(lat, busy_rdy);
  endtask

  task automatic consume_main();
    d_out_ready = 1'b1;
    @(negedge clock);
    d_out_ready = 1'b0;
    chk("consume_valid", d_out_valid, 1'b0);
    chk("consume_state", d_dbg, ST_IDLE);
  endtask

  task automatic run_sweep(input logic [127:0] data, input logic inv, input logic [127:0] exp_data);
    int lat [4];
    for (int i = 0; i < 4; i++) lat[i] = 99;
    @(negedge clock);
    chk("sw_in_ready", s_in_ready, 4'hf);
    s_in_valid = 1'b1; s_in_data = data; s_in_inverse = inv;
    @(negedge clock);
    s_in_valid = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      for (int i = 0; i < 4; i++)
        if (lat[i] == 99 && s_out_valid[i]) lat[i] = k;
      if (k < 20) @(negedge clock);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sw%0d_lat", i), 128'(lat[i]), 128'(exp_lat[i]));
      chk($sformatf("sw%0d_data", i), s_out_data[i], exp_data);
      chk($sformatf("sw%0d_inv", i), s_out_inverse[i], inv);
    end
    s_out_ready = 1'b1;
    @(negedge clock);
    s_out_ready = 1'b0;
    chk("sw_consumed", s_out_valid, 4'h0);
  endtask

  initial begin
    int   lat;
    logic busy_rdy;
    logic [127:0] held;
    reset = 1'b1;
    d_in_valid = 1'b0; d_in_data = '0; d_in_inverse = 1'b0; d_out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_inverse = 1'b0; s_out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_in_ready", d_in_ready, 1'b0);
    chk("rst_out_valid", d_out_valid, 1'b0);
    chk("rst_out_inv", d_out_inverse, 1'b0);
    chk("rst_state", d_dbg, ST_IDLE);
    chk("rst_sw_in_ready", s_in_ready, 4'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_in_ready", d_in_ready, 1'b1);

    // FIPS-197 forward vector
    run_main(V_PT, 1'b0, lat, busy_rdy);
    chk("fwd_lat", 128'(lat), 128'd4);
    chk("fwd_data", d_out_data, V_SB);
    chk("fwd_inv", d_out_inverse, 1'b0);
    chk("fwd_busy_in_ready", busy_rdy, 1'b0);

    // back-pressure: result frozen for 10 cycles
    held = d_out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_valid", d_out_valid, 1'b1);
      chk("bp_data", d_out_data, V_SB);
      chk("bp_inv", d_out_inverse, 1'b0);
      chk("bp_in_ready", d_in_ready, 1'b0);
    end

    // consume and accept inverse vector on the same edge
    d_out_ready = 1'b1; d_in_valid = 1'b1; d_in_data = V_SB; d_in_inverse = 1'b1;
    #1;
    chk("b2b_in_ready", d_in_ready, 1'b1);
    @(negedge clock);
    d_out_ready = 1'b0; d_in_valid = 1'b0;
    chk("b2b_state", d_dbg, ST_BUSY);
    chk("b2b_valid", d_out_valid, 1'b0);
    wait_main(lat, busy_rdy);
    chk("inv_lat", 128'(lat), 128'd4);
    chk("inv_data", d_out_data, V_PT);
    chk("inv_inv", d_out_inverse, 1'b1);
    chk("inv_busy_in_ready", busy_rdy, 1'b0);
    consume_main();

    // reset two cycles into BUSY
    @(negedge clock);
    d_in_valid = 1'b1; d_in_data = V_PT; d_in_inverse = 1'b0;
    @(negedge clock);
    d_in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_valid", d_out_valid, 1'b0);
    chk("midrst_state", d_dbg, ST_IDLE);
    chk("midrst_in_ready", d_in_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("postrst_in_ready", d_in_ready, 1'b1);
    chk("postrst_state", d_dbg, ST_IDLE);
    run_main(V_PT, 1'b0, lat, busy_rdy);
    chk("postrst_lat", 128'(lat), 128'd4);
    chk("postrst_data", d_out_data, V_SB);
    consume_main();

    // mode isolation on the all-zero state
    for (int i = 0; i < 4; i++) begin
      run_main(ZERO, i[0], lat, busy_rdy);
      chk("mode_data", d_out_data, i[0] ? ALL52 : ALL63);
      chk("mode_inv", d_out_inverse, i[0]);
      consume_main();
    end

    // reset while holding a result in DONE
    run_main(ZERO, 1'b1, lat, busy_rdy);
    chk("done_valid_pre", d_out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("donerst_valid", d_out_valid, 1'b0);
    chk("donerst_inv", d_out_inverse, 1'b0);
    chk("donerst_state", d_dbg, ST_IDLE);
    @(negedge clock);
    reset = 1'b0;

    // LANES sweep
    run_sweep(V_PT, 1'b0, V_SB);
    run_sweep(V_SB, 1'b1, V_PT);
    run_sweep(ZERO, 1'b0, ALL63);
    run_sweep(ALL63, 1'b1, ZERO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
